ifmap_word_streamer: RTL

Sequencer and unpacker placed around the 8-way input-feature ROM select multiplexer. It drives the 3-bit feature select `F` and the shared ROM address, captures the selected 192-bit ROM word, and streams it out as 16-bit elements over a valid/ready interface to the convolution MAC datapath. One `start` walks all 8 input features, `num_words` words each, then pulses `done`.

---
 rtl/ifmap_word_streamer_pkg.sv | 20 ++
 rtl/ifmap_word_streamer_unpack.sv | 51 +++++
 rtl/ifmap_word_streamer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ifmap_word_streamer_pkg.sv
// Shared constants and FSM encoding for the input-feature word streamer.
// Sizes match the 8-way ROM mux feeding the conv MAC datapath.
package ifmap_word_streamer_pkg;

    localparam int WORD_W = 192;
    localparam int ELEM_W = 16;
    localparam int N_ELEM = WORD_W / ELEM_W;
    localparam int F_W    = 3;
    localparam int N_IF   = 2 ** F_W;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_STREAM  = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

endpackage

// File: rtl/ifmap_word_streamer_unpack.sv
// Word register with indexed element extraction.
// The index only moves on a handshake, so the element holds during stalls.
module word_unpack_reg #(
    parameter int WORD_W = 192,
    parameter int ELEM_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_adv,
    output logic [ELEM_W-1:0] o_elem,
    output logic              o_idx_last
);

    localparam int N_ELEM = WORD_W / ELEM_W;
    localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic              w_idx_last;
    logic [ELEM_W-1:0] w_elem;

    assign w_idx_last = (r_idx == IDX_W'(N_ELEM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_word <= i_data;
            r_idx  <= '0;
        end else if (i_adv) begin
            r_idx  <= w_idx_last ? '0 : r_idx + 1'b1;
        end
    end

    // Element 0 sits in the LSBs of the word.
    always_comb begin
        w_elem = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_elem = r_word[i*ELEM_W +: ELEM_W];
            end
        end
    end

    assign o_elem     = w_elem;
    assign o_idx_last = w_idx_last;

endmodule

// File: rtl/ifmap_word_streamer.sv
// Sequences F/rom_addr across all input features and streams each
// captured ROM word as elements over a valid/ready link.
module ifmap_word_streamer #(
    parameter int WORD_W = ifmap_word_streamer_pkg::WORD_W,
    parameter int ELEM_W = ifmap_word_streamer_pkg::ELEM_W,
    parameter int N_IF   = ifmap_word_streamer_pkg::N_IF,
    parameter int F_W    = ifmap_word_streamer_pkg::F_W,
    parameter int ADDR_W = ifmap_word_streamer_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_words,
    output logic [F_W-1:0]    F,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [ELEM_W-1:0] elem_out,
    output logic              elem_valid,
    input  logic              elem_ready,
    output logic              elem_last,
    output logic              if_last,
    output logic              busy,
    output logic              done
);

    import ifmap_word_streamer_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic [F_W-1:0]    r_f;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_nw;

    logic              w_stream;
    logic              w_hs;
    logic              w_idx_last;
    logic              w_word_end;
    logic              w_addr_end;
    logic              w_f_end;
    logic              w_start_ok;
    logic [ELEM_W-1:0] w_elem;

    assign w_stream   = (r_state == ST_STREAM);
    assign w_hs       = w_stream & elem_ready;
    assign w_word_end = w_hs & w_idx_last;
    assign w_addr_end = (r_addr == ADDR_W'(r_nw - 1'b1));
    assign w_f_end    = (r_f == F_W'(N_IF - 1));
    assign w_start_ok = (r_state == ST_IDLE) & start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (num_words != '0) ? ST_FETCH : ST_FINISH;
                end
            end
            ST_FETCH:   w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_STREAM;
            ST_STREAM: begin
                if (w_word_end) begin
                    w_next = (w_addr_end && w_f_end) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FINISH:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Every accepted start rewinds to F0/addr0, even an empty pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f    <= '0;
            r_addr <= '0;
            r_nw   <= '0;
        end else if (w_start_ok) begin
            r_f    <= '0;
            r_addr <= '0;
            r_nw   <= num_words;
        end else if (w_word_end) begin
            if (!w_addr_end) begin
                r_addr <= r_addr + 1'b1;
            end else if (!w_f_end) begin
                r_f    <= r_f + 1'b1;
                r_addr <= '0;
            end
        end
    end

    word_unpack_reg #(
        .WORD_W (WORD_W),
        .ELEM_W (ELEM_W)
    ) u_unpack (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (r_state == ST_CAPTURE),
        .i_data     (rom_data),
        .i_adv      (w_hs),
        .o_elem     (w_elem),
        .o_idx_last (w_idx_last)
    );

    assign F          = r_f;
    assign rom_addr   = r_addr;
    assign elem_out   = w_elem;
    assign elem_valid = w_stream;
    assign elem_last  = w_stream & w_idx_last;
    assign if_last    = w_stream & w_idx_last & w_addr_end;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_FINISH);

endmodule
